// File: rtl/cic_comp_fir_pkg.sv
// Shared definitions for the CIC droop-compensation FIR: FSM state type,
// default coefficient set, and width helpers.
package cic_comp_fir_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MAC   = 2'd1,
    ST_ROUND = 2'd2
  } fir_state_t;

  localparam int DEF_COEF_WIDTH = 16;
  localparam int NUM_COEF       = 16;

  // Symmetric, sums to 2^15 (unity DC gain). The alternating-sign taps
  // next to the centre pair lift the upper passband against the sinc^5 droop.
  localparam logic signed [DEF_COEF_WIDTH-1:0] COEF_TAB [NUM_COEF] = '{
    -16'sd20,   16'sd45,  -16'sd80,   16'sd120,
    -16'sd190,  16'sd330, -16'sd900,  16'sd17079,
     16'sd17079, -16'sd900, 16'sd330, -16'sd190,
     16'sd120,  -16'sd80,  16'sd45,  -16'sd20
  };

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

  // Wide enough that TAPS full-scale products can never wrap.
  function automatic int acc_width(input int width, input int coef_width, input int taps);
    return width + coef_width + clog2(taps);
  endfunction

endpackage

// File: rtl/cic_comp_fir_if.sv
// Sample-stream interface between the CIC output and the compensation FIR.
interface cic_comp_fir_if #(
  parameter int WIDTH = 16
) ();
  logic signed [WIDTH-1:0] data_in;
  logic                    stb_in;
  logic signed [WIDTH-1:0] data_out;
  logic                    stb_out;
  logic                    busy;
  logic                    overrun;

  modport master (
    output data_in, stb_in,
    input  data_out, stb_out, busy, overrun
  );

  modport slave (
    input  data_in, stb_in,
    output data_out, stb_out, busy, overrun
  );
endinterface

// File: rtl/cic_comp_fir_coef_rom.sv
// Combinational tap-index to coefficient lookup; swapping the coefficient
// set only touches this file and the package table.
module cic_comp_coef_rom
  import cic_comp_fir_pkg::*;
#(
  parameter int COEF_WIDTH = 16,
  parameter int IDX_W      = 4
) (
  input  logic [IDX_W-1:0]             idx,
  output logic signed [COEF_WIDTH-1:0] coef
);

  localparam int TAB_IDX_W = clog2(NUM_COEF);

  int idx_i;

  // Taps beyond the stored table read as zero.
  always_comb begin
    idx_i = int'(idx);
    coef  = '0;
    if (idx_i < NUM_COEF) begin
      coef = COEF_WIDTH'(COEF_TAB[idx_i[TAB_IDX_W-1:0]]);
    end
  end

endmodule

// File: rtl/cic_comp_fir.sv
// Decimating CIC droop-compensation FIR with one time-shared multiplier.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   ST_IDLE  | waiting for samples; accepted strobes fill the ring buffer
//   ST_MAC   | TAPS cycles, one coefficient x sample product per cycle
//   ST_ROUND | round, shift, saturate; result registered onto data_out
module cic_comp_fir
  import cic_comp_fir_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int COEF_WIDTH = 16,
  parameter int TAPS       = 16,
  parameter int DECIM      = 2
) (
  input  logic          clk,
  input  logic          rst,
  cic_comp_fir_if.slave bus
);

  localparam int PTR_W  = clog2(TAPS);
  localparam int PH_W   = (DECIM > 1) ? clog2(DECIM) : 1;
  localparam int ACC_W  = acc_width(WIDTH, COEF_WIDTH, TAPS);
  localparam int PROD_W = WIDTH + COEF_WIDTH;

  localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(DECIM - 1);
  localparam logic [PTR_W-1:0] TAP_LAST = PTR_W'(TAPS - 1);

  localparam logic signed [ACC_W-1:0] RND_HALF =
    {{(ACC_W-COEF_WIDTH+1){1'b0}}, 1'b1, {(COEF_WIDTH-2){1'b0}}};
  localparam logic signed [ACC_W-1:0] SAT_MAX =
    {{(ACC_W-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN =
    {{(ACC_W-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

  fir_state_t state, state_nxt;

  logic signed [WIDTH-1:0]      smp_mem [TAPS];
  logic [PTR_W-1:0]             wp;
  logic [PTR_W-1:0]             snap;
  logic [PTR_W-1:0]             tap;
  logic [PTR_W-1:0]             rd_addr;
  logic [PH_W-1:0]              phase;
  logic signed [ACC_W-1:0]      acc;
  logic signed [COEF_WIDTH-1:0] coef;
  logic signed [PROD_W-1:0]     prod;
  logic signed [ACC_W-1:0]      rnd_sum;
  logic signed [ACC_W-1:0]      rnd_shr;
  logic signed [WIDTH-1:0]      sat_val;
  logic signed [WIDTH-1:0]      data_out_r;
  logic                         stb_out_r;
  logic                         overrun_r;
  logic                         accept;
  logic                         trigger;
  logic                         mac_start;

  assign accept  = bus.stb_in && (state == ST_IDLE);
  assign trigger = accept && (phase == PH_LAST);

  // Newest sample sits at snap; tap i reaches i samples further back.
  assign rd_addr = snap - tap;

  cic_comp_coef_rom #(
    .COEF_WIDTH (COEF_WIDTH),
    .IDX_W      (PTR_W)
  ) u_coef_rom (
    .idx  (tap),
    .coef (coef)
  );

  assign prod = PROD_W'(smp_mem[rd_addr]) * PROD_W'(coef);

  // Round half up, drop the Q1.15 fraction, clamp to the output range.
  always_comb begin
    rnd_sum = acc + RND_HALF;
    rnd_shr = rnd_sum >>> (COEF_WIDTH - 1);
    if (rnd_shr > SAT_MAX) begin
      sat_val = {1'b0, {(WIDTH-1){1'b1}}};
    end else if (rnd_shr < SAT_MIN) begin
      sat_val = {1'b1, {(WIDTH-1){1'b0}}};
    end else begin
      sat_val = rnd_shr[WIDTH-1:0];
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: a triggering sample starts the MAC run.
  always_comb begin
    state_nxt = state;
    mac_start = 1'b0;
    case (state)
      ST_IDLE: begin
        if (trigger) begin
          state_nxt = ST_MAC;
          mac_start = 1'b1;
        end
      end
      ST_MAC: begin
        if (tap == TAP_LAST) begin
          state_nxt = ST_ROUND;
        end
      end
      ST_ROUND: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Ring buffer, phase counter, MAC datapath and output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < TAPS; i++) begin
        smp_mem[i] <= '0;
      end
      wp         <= '0;
      snap       <= '0;
      tap        <= '0;
      phase      <= '0;
      acc        <= '0;
      data_out_r <= '0;
      stb_out_r  <= 1'b0;
      overrun_r  <= 1'b0;
    end else begin
      stb_out_r <= 1'b0;

      if (accept) begin
        smp_mem[wp] <= bus.data_in;
        wp          <= wp + 1'b1;
        phase       <= trigger ? '0 : phase + 1'b1;
      end

      if (bus.stb_in && (state != ST_IDLE)) begin
        overrun_r <= 1'b1;
      end

      if (mac_start) begin
        snap <= wp;
        tap  <= '0;
        acc  <= '0;
      end else if (state == ST_MAC) begin
        acc <= acc + ACC_W'(prod);
        tap <= tap + 1'b1;
      end

      if (state == ST_ROUND) begin
        data_out_r <= sat_val;
        stb_out_r  <= 1'b1;
      end
    end
  end

  assign bus.data_out = data_out_r;
  assign bus.stb_out  = stb_out_r;
  assign bus.busy     = (state != ST_IDLE);
  assign bus.overrun  = overrun_r;

endmodule

// File: tb/tb_cic_comp_fir.sv
// Randomised scoreboard bench for cic_comp_fir against a plain-arithmetic
// FIR model driven by accepted-sample history.
module tb_cic_comp_fir;

  localparam int WIDTH      = 16;
  localparam int COEF_WIDTH = 16;
  localparam int TAPS       = 16;
  localparam int DECIM      = 2;

  typedef struct {
    int e;
    int v;
  } exp_item_t;

  logic clk;
  logic rst;
  int   edge_cnt;
  int   checks;
  int   failures;
  bit   mon_en;

  int ref_coef [TAPS] = '{-20, 45, -80, 120, -190, 330, -900, 17079,
                          17079, -900, 330, -190, 120, -80, 45, -20};

  exp_item_t exp_q [$];
  int        hist  [$];
  int        phase_m;
  int        last_trig;
  int        ovr_edge;
  int        exp_hold;

  cic_comp_fir_if #(.WIDTH(WIDTH)) bus ();

  cic_comp_fir #(
    .WIDTH      (WIDTH),
    .COEF_WIDTH (COEF_WIDTH),
    .TAPS       (TAPS),
    .DECIM      (DECIM)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, edge_cnt);
    end
  endtask

  function automatic int model_out();
    longint acc;
    longint r;
    int     idx;
    acc = 0;
    for (int i = 0; i < TAPS; i++) begin
      idx = hist.size() - 1 - i;
      if (idx >= 0) acc += longint'(ref_coef[i]) * longint'(hist[idx]);
    end
    r = (acc + 64'sd16384) >>> 15;
    if (r > 32767) r = 32767;
    else if (r < -32768) r = -32768;
    return int'(r);
  endfunction

  function automatic void model_clear();
    hist.delete();
    exp_q.delete();
    phase_m   = 0;
    last_trig = -1000;
    ovr_edge  = 32'h7fffffff;
    exp_hold  = 0;
  endfunction

  // A strobe sampled at edge s is taken only once the previous computation
  // has finished (TAPS+2 edges after its trigger); otherwise it is dropped.
  function automatic void model_sample(input int s, input int val);
    exp_item_t it;
    if (s < last_trig + TAPS + 2) begin
      if (s < ovr_edge) ovr_edge = s;
    end else begin
      hist.push_back(val);
      if (hist.size() > TAPS) void'(hist.pop_front());
      phase_m = (phase_m + 1) % DECIM;
      if (phase_m == 0) begin
        last_trig = s;
        it.e = s + TAPS + 1;
        it.v = model_out();
        exp_q.push_back(it);
      end
    end
  endfunction

  task automatic send(input int val, input int spacing);
    repeat (spacing - 2) @(posedge clk);
    @(posedge clk); #1;
    bus.stb_in  = 1'b1;
    bus.data_in = 16'(val);
    model_sample(edge_cnt + 1, val);
    @(posedge clk); #1;
    bus.stb_in  = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_data_out"}, int'(bus.data_out), 0);
    chk({tag, "_stb_out"}, int'(bus.stb_out), 0);
    chk({tag, "_busy"}, int'(bus.busy), 0);
    chk({tag, "_overrun"}, int'(bus.overrun), 0);
  endtask

  task automatic do_reset(input int with_stb, input int val);
    @(posedge clk); #1;
    rst = 1'b1;
    if (with_stb != 0) begin
      bus.stb_in  = 1'b1;
      bus.data_in = 16'(val);
    end
    @(posedge clk); #1;
    rst        = 1'b0;
    bus.stb_in = 1'b0;
    model_clear();
  endtask

  // Monitor: every cycle compare strobe timing, value/hold, busy, overrun.
  always @(negedge clk) begin : mon
    bit        exp_now;
    bit        busy_exp;
    exp_item_t it;
    if (mon_en) begin
      while (exp_q.size() > 0 && exp_q[0].e < edge_cnt) void'(exp_q.pop_front());
      exp_now = (exp_q.size() > 0) && (exp_q[0].e == edge_cnt);
      chk("stb_out", int'(bus.stb_out), int'(exp_now));
      if (exp_now) begin
        it = exp_q.pop_front();
        chk("data_out", int'(bus.data_out), it.v);
        exp_hold = it.v;
      end else begin
        chk("data_hold", int'(bus.data_out), exp_hold);
      end
      busy_exp = (edge_cnt >= last_trig) && (edge_cnt <= last_trig + TAPS);
      chk("busy", int'(bus.busy), int'(busy_exp));
      chk("overrun", int'(bus.overrun), int'(edge_cnt >= ovr_edge));
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic signed [15:0] r16;
    int sp;
    int sgn;

    checks      = 0;
    failures    = 0;
    mon_en      = 1'b0;
    rst         = 1'b1;
    bus.stb_in  = 1'b0;
    bus.data_in = '0;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    model_clear();
    mon_en = 1'b1;
    check_reset_state("rst");

    // DC: settles to exactly the input level.
    for (int i = 0; i < 64; i++) send(32'h1000, 40);
    repeat (25) @(posedge clk);
    chk("dc_settle", int'(bus.data_out), 4096);

    // Impulse response.
    do_reset(0, 0);
    send(32767, 20);
    for (int i = 0; i < 20; i++) send(0, 20);
    repeat (25) @(posedge clk);
    chk("impulse_tail", int'(bus.data_out), 0);

    // Saturation with sign-matched full-scale pattern, then negated.
    do_reset(0, 0);
    for (int j = TAPS - 1; j >= 0; j--) send((ref_coef[j] < 0) ? -32767 : 32767, 20);
    repeat (25) @(posedge clk);
    chk("sat_pos", int'(bus.data_out), 32767);
    for (int j = TAPS - 1; j >= 0; j--) send((ref_coef[j] < 0) ? 32767 : -32767, 20);
    repeat (25) @(posedge clk);
    chk("sat_neg", int'(bus.data_out), -32768);

    // Overrun: strobe 3 cycles after a trigger is dropped, flag sticks.
    do_reset(0, 0);
    send(1000, 20);
    send(2000, 20);
    send(3000, 3);
    repeat (20) @(posedge clk);
    chk("ovr_flag", int'(bus.overrun), 1);
    send(-500, 20);
    send(700, 20);
    repeat (25) @(posedge clk);
    chk("ovr_sticky", int'(bus.overrun), 1);

    // Reset in the middle of a MAC run.
    do_reset(0, 0);
    send(5000, 20);
    send(-7000, 20);
    repeat (3) @(posedge clk);
    do_reset(0, 0);
    check_reset_state("rst_mid_mac");
    send(256, 20);
    send(256, 20);
    repeat (25) @(posedge clk);
    chk("post_rst_out", int'(bus.data_out), 0);

    // Reset wins over a simultaneous strobe.
    do_reset(1, 12345);
    check_reset_state("rst_with_stb");
    send(20000, 20);
    send(-15000, 20);
    repeat (25) @(posedge clk);

    // Random samples, mostly legal spacing with occasional overruns.
    do_reset(0, 0);
    for (int i = 0; i < 150; i++) begin
      r16 = 16'($urandom);
      sp  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(2, 17))
                                        : int'($urandom_range(18, 30));
      sgn = int'(r16);
      send(sgn, sp);
    end

    for (int k = 0; k < 100 && exp_q.size() > 0; k++) @(posedge clk);
    repeat (3) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
